// File: rtl/decrypt_pkg.sv
// Shared definitions for the decrypt-side frame path.
// Frame geometry, field bounds and the loader state encoding.
package decrypt_pkg;

    localparam int SYM_W   = 6;
    localparam int NUM_SYM = 13;
    localparam int FRAME_W = SYM_W * NUM_SYM;

    localparam int Y_MSB   = 77;
    localparam int Y_LSB   = 17;
    localparam int KEY_MSB = 16;
    localparam int KEY_LSB = 6;
    localparam int CHK_MSB = 5;
    localparam int CHK_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/frame_checksum.sv
// XOR-fold of every symbol above the checksum field.
// ok is high when the fold equals the low checksum symbol.
module frame_checksum #(
    parameter int SYM_W   = 6,
    parameter int NUM_SYM = 13
) (
    input  logic [SYM_W*NUM_SYM-1:0] frame,
    output logic                     ok
);

    logic [SYM_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 1; i < NUM_SYM; i++) begin
            acc = acc ^ frame[i*SYM_W +: SYM_W];
        end
        ok = (acc == frame[SYM_W-1:0]);
    end

endmodule

// File: rtl/decrypt_frame_loader.sv
// Assembles 6-bit symbols into a checked 78-bit frame for decrypt_function_3.
// Bad or aborted frames are dropped and counted in a saturating counter.
module decrypt_frame_loader #(
    parameter int SYM_W     = decrypt_pkg::SYM_W,
    parameter int NUM_SYM   = decrypt_pkg::NUM_SYM,
    parameter int ERR_CNT_W = 8,
    localparam int FRAME_W  = SYM_W * NUM_SYM
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [SYM_W-1:0]     in_sym,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_W-1:0]   data_1,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    import decrypt_pkg::*;

    localparam int CNT_W  = $clog2(NUM_SYM + 1);
    localparam int HIST_W = FRAME_W - SYM_W;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [HIST_W-1:0]   shreg;
    logic [FRAME_W-1:0]  frame;
    logic                chk_ok;
    logic                accept;
    logic                restart;
    logic                shift;
    logic                load;
    logic                drop;

    // Earlier symbols sit in shreg; the last beat completes the frame in flight.
    assign frame     = {shreg, in_sym};
    assign in_ready  = !Reset && (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    frame_checksum #(
        .SYM_W  (SYM_W),
        .NUM_SYM(NUM_SYM)
    ) u_chk (
        .frame(frame),
        .ok   (chk_ok)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        restart    = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && in_sof) begin
                    restart    = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (in_sof) begin
                        restart = 1'b1;
                        drop    = 1'b1;
                    end else if (cnt == CNT_W'(NUM_SYM - 1)) begin
                        if (chk_ok) begin
                            load       = 1'b1;
                            next_state = HOLD;
                        end else begin
                            drop       = 1'b1;
                            next_state = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt       <= '0;
            shreg     <= '0;
            data_1    <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= drop;
            if (drop && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
            if (restart) begin
                shreg <= HIST_W'(in_sym);
                cnt   <= CNT_W'(1);
            end else if (shift) begin
                shreg <= {shreg[HIST_W-SYM_W-1:0], in_sym};
                cnt   <= cnt + 1'b1;
            end else if (load || drop) begin
                cnt <= '0;
            end
            if (load) data_1 <= frame;
        end
    end

endmodule

// File: tb/tb_decrypt_frame_loader.sv
// Directed testbench for decrypt_frame_loader.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_decrypt_frame_loader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [5:0]  in_sym;
    logic        out_valid;
    logic        out_ready;
    logic [77:0] data_1;
    logic        frame_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;

    localparam logic [77:0] GOOD = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6,
                                    6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                                    6'h0C};
    localparam logic [77:0] BAD  = {GOOD[77:6], 6'h0D};

    always #5 Clk = ~Clk;

    decrypt_frame_loader dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .in_sym   (in_sym),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_1   (data_1),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    task automatic tick();
        @(negedge Clk);
        if (frame_err) err_seen++;
    endtask

    task automatic send_sym(input logic [5:0] s, input logic sof);
        in_valid = 1'b1;
        in_sym   = s;
        in_sof   = sof;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [77:0] f, input int first,
                              input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            send_sym(f[77-6*i -: 6], i == 0);
            if (gap != 0 && (i % 3) == 1 && i != last) begin
                repeat (gap) tick();
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        err_seen = 0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_sym    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b frame_err=%b want 0 0 0",
                     in_ready, out_valid, frame_err);
        end
        checks++;
        if (data_1 !== 78'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: data_1=%h err_count=%0d want 0 0", data_1, err_count);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
        err_seen = 0;
    endtask

    task automatic test_good_frame();
        do_reset();
        out_ready = 1'b1;
        send_range(GOOD, 0, 11, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_early: out_valid=%b want 0", out_valid);
        end
        send_sym(GOOD[5:0], 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_1 !== GOOD) begin
            failures++;
            $display("FAIL good_out: out_valid=%b data_1=%h want 1 %h", out_valid, data_1, GOOD);
        end
        checks++;
        if (data_1[16:6] !== 11'h2CC || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL good_key: key=%h in_ready=%b want 2cc 0", data_1[16:6], in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_seen !== 0) begin
            failures++;
            $display("FAIL good_done: out_valid=%b in_ready=%b errs=%0d want 0 1 0",
                     out_valid, in_ready, err_seen);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        out_ready = 1'b0;
        send_range(GOOD, 0, 12, 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_1 !== GOOD) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: unstable cycles=%0d want 0 (data_1=%h)", bad, data_1);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        out_ready = 1'b1;
        send_range(BAD, 0, 12, 0);
        checks++;
        if (out_valid !== 1'b0 || frame_err !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL bad_chk: out_valid=%b frame_err=%b err_count=%0d want 0 1 1",
                     out_valid, frame_err, err_count);
        end
        tick();
        tick();
        checks++;
        if (frame_err !== 1'b0 || err_seen !== 1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL bad_pulse: frame_err=%b pulses=%0d err_count=%0d want 0 1 1",
                     frame_err, err_seen, err_count);
        end
    endtask

    task automatic test_mid_sof();
        do_reset();
        out_ready = 1'b1;
        send_range(GOOD, 0, 4, 0);
        send_sym(GOOD[77:72], 1'b1);
        checks++;
        if (frame_err !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL sof_abort: frame_err=%b err_count=%0d want 1 1", frame_err, err_count);
        end
        send_range(GOOD, 1, 12, 0);
        checks++;
        if (out_valid !== 1'b1 || data_1 !== GOOD || err_seen !== 1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL sof_second: out_valid=%b data_1=%h errs=%0d cnt=%0d want 1 %h 1 1",
                     out_valid, data_1, err_seen, err_count, GOOD);
        end
        tick();
    endtask

    task automatic test_gaps();
        do_reset();
        out_ready = 1'b1;
        send_sym(6'h2A, 1'b0);
        send_sym(6'h15, 1'b0);
        send_sym(6'h3F, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'd0 || err_seen !== 0) begin
            failures++;
            $display("FAIL stray: in_ready=%b out_valid=%b err_count=%0d errs=%0d want 1 0 0 0",
                     in_ready, out_valid, err_count, err_seen);
        end
        send_range(GOOD, 0, 11, 2);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gap_early: out_valid=%b want 0", out_valid);
        end
        send_sym(GOOD[5:0], 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_1 !== GOOD || err_seen !== 0) begin
            failures++;
            $display("FAIL gap_frame: out_valid=%b data_1=%h errs=%0d want 1 %h 0",
                     out_valid, data_1, err_seen, GOOD);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || data_1 !== GOOD) begin
            failures++;
            $display("FAIL gap_keep: out_valid=%b data_1=%h want 0 %h", out_valid, data_1, GOOD);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        out_ready = 1'b1;
        send_range(GOOD, 0, 6, 0);
        Reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || data_1 !== 78'd0) begin
            failures++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b data_1=%h want 0 0 0",
                     in_ready, out_valid, data_1);
        end
        Reset = 1'b0;
        tick();
        send_range(GOOD, 7, 12, 0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || err_seen !== 0) begin
            failures++;
            $display("FAIL rst_after: out_valid=%b err_count=%0d errs=%0d want 0 0 0",
                     out_valid, err_count, err_seen);
        end
    endtask

    task automatic test_back_to_back_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++) begin
            send_range(BAD, 0, 12, 0);
            if (k == 253) begin
                checks++;
                if (err_count !== 8'd254) begin
                    failures++;
                    $display("FAIL sat_254: err_count=%0d want 254", err_count);
                end
            end
            if (k == 254) begin
                checks++;
                if (err_count !== 8'd255) begin
                    failures++;
                    $display("FAIL sat_255: err_count=%0d want 255", err_count);
                end
            end
        end
        tick();
        checks++;
        if (err_count !== 8'd255 || err_seen !== 260 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_end: err_count=%0d pulses=%0d out_valid=%b want 255 260 0",
                     err_count, err_seen, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_checksum();
        test_mid_sof();
        test_gaps();
        test_reset_mid_load();
        test_back_to_back_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
